// File: rtl/ahb_lite_slave_mux4_if.sv
// ahb_lite_slave_mux4_if
// Bus bundle around the AHB-Lite decoder/mux: the CPU-side master port
// (M_*), the broadcast copies sent to every slave (S_*), and the per-slave
// select/response signals (Sn_*).
// Modports:
//   slave  - view of the mux itself (it is the slave of the CPU port and
//            drives the slave-side selects and broadcasts)
//   master - view of the surrounding system (CPU and the four slaves)
interface ahb_lite_slave_mux4_if;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic [31:0] M_HADDR;
    logic [31:0] M_HWDATA;
    logic        M_HREADY;
    logic [31:0] M_HRDATA;
    logic        M_HRESP;

    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HADDR;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;

    logic        S0_HSEL, S1_HSEL, S2_HSEL, S3_HSEL;
    logic        S0_HREADYOUT, S1_HREADYOUT, S2_HREADYOUT, S3_HREADYOUT;
    logic [31:0] S0_HRDATA, S1_HRDATA, S2_HRDATA, S3_HRDATA;
    logic        S0_HRESP, S1_HRESP, S2_HRESP, S3_HRESP;

    modport slave (
        input  M_HTRANS, M_HWRITE, M_HSIZE, M_HADDR, M_HWDATA,
        output M_HREADY, M_HRDATA, M_HRESP,
        output S_HTRANS, S_HWRITE, S_HSIZE, S_HADDR, S_HWDATA, S_HREADY,
        output S0_HSEL, S1_HSEL, S2_HSEL, S3_HSEL,
        input  S0_HREADYOUT, S1_HREADYOUT, S2_HREADYOUT, S3_HREADYOUT,
        input  S0_HRDATA, S1_HRDATA, S2_HRDATA, S3_HRDATA,
        input  S0_HRESP, S1_HRESP, S2_HRESP, S3_HRESP
    );

    modport master (
        output M_HTRANS, M_HWRITE, M_HSIZE, M_HADDR, M_HWDATA,
        input  M_HREADY, M_HRDATA, M_HRESP,
        input  S_HTRANS, S_HWRITE, S_HSIZE, S_HADDR, S_HWDATA, S_HREADY,
        input  S0_HSEL, S1_HSEL, S2_HSEL, S3_HSEL,
        output S0_HREADYOUT, S1_HREADYOUT, S2_HREADYOUT, S3_HREADYOUT,
        output S0_HRDATA, S1_HRDATA, S2_HRDATA, S3_HRDATA,
        output S0_HRESP, S1_HRESP, S2_HRESP, S3_HRESP
    );
endinterface

// File: rtl/ahb_lite_slave_mux4.sv
// ahb_lite_slave_mux4
// Address decoder and response mux between the CPU AHB-Lite port and four
// slaves (slave 0 is the on-chip RAM), with a built-in default slave that
// returns a two-cycle ERROR for unmapped or misaligned transfers, and a
// sticky error log.
// Ports:
//   CLK, RES   - clock, synchronous active-high reset
//   bus        - AHB-Lite bundle (slave modport of ahb_lite_slave_mux4_if)
//   ERR_CLR    - clears the error counter
//   ERR_COUNT  - saturating count of default-slave errors
//   ERR_ADDR   - address of the most recent faulting transfer
//
// Default slave FSM:
//   state | meaning
//   OK    | no default-slave data phase in progress
//   ERR1  | first ERROR cycle, HREADY low
//   ERR2  | second ERROR cycle, HREADY high, next address phase accepted
module ahb_lite_slave_mux4 #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S3_BASE = 32'h4000_1000,
    parameter logic [31:0] S3_MASK = 32'hFFFF_F000
) (
    input  logic                         CLK,
    input  logic                         RES,
    ahb_lite_slave_mux4_if.slave         bus,
    input  logic                         ERR_CLR,
    output logic [7:0]                   ERR_COUNT,
    output logic [31:0]                  ERR_ADDR
);

    typedef enum logic [2:0] {
        DSEL_NONE, DSEL_S0, DSEL_S1, DSEL_S2, DSEL_S3, DSEL_DEF
    } dsel_e;

    typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_e;

    dsel_e       dsel_q, dsel_d;
    state_e      state_q, state_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [3:0]  hit;
    logic [3:0]  sel;
    logic        misaligned;
    logic        new_def;
    logic        accept;
    logic        err_event;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    // Combinational decode; a misaligned transfer selects nobody even on a hit.
    always_comb begin
        hit[0] = (bus.M_HADDR & S0_MASK) == S0_BASE;
        hit[1] = (bus.M_HADDR & S1_MASK) == S1_BASE;
        hit[2] = (bus.M_HADDR & S2_MASK) == S2_BASE;
        hit[3] = (bus.M_HADDR & S3_MASK) == S3_BASE;
        misaligned = (bus.M_HSIZE == 3'b001 && bus.M_HADDR[0])
                  || (bus.M_HSIZE == 3'b010 && bus.M_HADDR[1:0] != 2'b00)
                  || (bus.M_HSIZE > 3'b010);
        sel = 4'b0000;
        if (!misaligned) begin
            if (hit[0])      sel = 4'b0001;
            else if (hit[1]) sel = 4'b0010;
            else if (hit[2]) sel = 4'b0100;
            else if (hit[3]) sel = 4'b1000;
        end
    end

    assign new_def   = bus.M_HTRANS[1] && (sel == 4'b0000);
    assign accept    = hready;
    assign err_event = accept && new_def;

    always_comb begin
        dsel_d = dsel_q;
        if (accept) begin
            if (!bus.M_HTRANS[1]) dsel_d = DSEL_NONE;
            else if (new_def)     dsel_d = DSEL_DEF;
            else if (sel[0])      dsel_d = DSEL_S0;
            else if (sel[1])      dsel_d = DSEL_S1;
            else if (sel[2])      dsel_d = DSEL_S2;
            else                  dsel_d = DSEL_S3;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK:   if (err_event) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_event ? ST_ERR1 : ST_OK;
            default: state_d = ST_OK;
        endcase
    end

    // While the FSM is in OK the data-phase owner is never DEF, so the
    // slave mux only has to cover NONE and S0..S3.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'h0;
        case (state_q)
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: begin
                case (dsel_q)
                    DSEL_S0: begin
                        hready = bus.S0_HREADYOUT;
                        hresp  = bus.S0_HRESP;
                        hrdata = bus.S0_HRDATA;
                    end
                    DSEL_S1: begin
                        hready = bus.S1_HREADYOUT;
                        hresp  = bus.S1_HRESP;
                        hrdata = bus.S1_HRDATA;
                    end
                    DSEL_S2: begin
                        hready = bus.S2_HREADYOUT;
                        hresp  = bus.S2_HRESP;
                        hrdata = bus.S2_HRDATA;
                    end
                    DSEL_S3: begin
                        hready = bus.S3_HREADYOUT;
                        hresp  = bus.S3_HRESP;
                        hrdata = bus.S3_HRDATA;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // A clear that lands on a new error still counts that error.
    always_comb begin
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (err_event) begin
            err_addr_d = bus.M_HADDR;
            if (ERR_CLR)                    err_count_d = 8'd1;
            else if (err_count_q != 8'hFF)  err_count_d = err_count_q + 8'd1;
        end else if (ERR_CLR) begin
            err_count_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            dsel_q      <= DSEL_NONE;
            state_q     <= ST_OK;
            err_count_q <= 8'd0;
            err_addr_q  <= 32'h0;
        end else begin
            dsel_q      <= dsel_d;
            state_q     <= state_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign bus.M_HREADY = hready;
    assign bus.M_HRESP  = hresp;
    assign bus.M_HRDATA = hrdata;

    assign bus.S_HTRANS = bus.M_HTRANS;
    assign bus.S_HWRITE = bus.M_HWRITE;
    assign bus.S_HSIZE  = bus.M_HSIZE;
    assign bus.S_HADDR  = bus.M_HADDR;
    assign bus.S_HWDATA = bus.M_HWDATA;
    assign bus.S_HREADY = hready;

    assign bus.S0_HSEL = sel[0];
    assign bus.S1_HSEL = sel[1];
    assign bus.S2_HSEL = sel[2];
    assign bus.S3_HSEL = sel[3];

    assign ERR_COUNT = err_count_q;
    assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_ahb_lite_slave_mux4.sv
module tb_ahb_lite_slave_mux4;
    logic        CLK;
    logic        RES;
    logic        ERR_CLR;
    logic [7:0]  ERR_COUNT;
    logic [31:0] ERR_ADDR;

    int n_checks = 0;
    int n_fails  = 0;

    ahb_lite_slave_mux4_if bus();

    ahb_lite_slave_mux4 dut (
        .CLK       (CLK),
        .RES       (RES),
        .bus       (bus.slave),
        .ERR_CLR   (ERR_CLR),
        .ERR_COUNT (ERR_COUNT),
        .ERR_ADDR  (ERR_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Slave 0: small zero-wait RAM so write-then-read is observable end to end.
    logic [31:0] mem [0:63];
    logic        s0_rd_act, s0_wr_act;
    logic [5:0]  s0_idx;

    always @(posedge CLK) begin
        if (RES) begin
            s0_rd_act <= 1'b0;
            s0_wr_act <= 1'b0;
        end else if (bus.S_HREADY) begin
            if (s0_wr_act) mem[s0_idx] <= bus.S_HWDATA;
            s0_rd_act <= bus.S0_HSEL && bus.S_HTRANS[1] && !bus.S_HWRITE;
            s0_wr_act <= bus.S0_HSEL && bus.S_HTRANS[1] && bus.S_HWRITE;
            s0_idx    <= bus.S_HADDR[7:2];
        end
    end

    assign bus.S0_HRDATA    = s0_rd_act ? mem[s0_idx] : 32'h0;
    assign bus.S0_HREADYOUT = 1'b1;
    assign bus.S0_HRESP     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Target of an address phase: 0..3 for a slave, -1 for the default slave.
    function automatic int model_target(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] base [4] = '{32'h0000_0000, 32'h8000_0000, 32'h4000_0000, 32'h4000_1000};
        logic [31:0] mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};
        if (sz > 3'd2) return -1;
        if (sz == 3'd1 && (a % 2) != 0) return -1;
        if (sz == 3'd2 && (a % 4) != 0) return -1;
        for (int n = 0; n < 4; n++)
            if ((a & mask[n]) == base[n]) return n;
        return -1;
    endfunction

    function automatic logic [33:0] slave_resp(input int n);
        case (n)
            0: return {bus.S0_HREADYOUT, bus.S0_HRESP, bus.S0_HRDATA};
            1: return {bus.S1_HREADYOUT, bus.S1_HRESP, bus.S1_HRDATA};
            2: return {bus.S2_HREADYOUT, bus.S2_HRESP, bus.S2_HRDATA};
            default: return {bus.S3_HREADYOUT, bus.S3_HRESP, bus.S3_HRDATA};
        endcase
    endfunction

    int          m_owner  = -1;   // -1 none, 0..3 slave, 4 default slave
    int          m_err_cyc = 0;   // 1 or 2 = which ERROR cycle we are in
    int          m_cnt    = 0;
    logic [31:0] m_addr   = 32'h0;

    always @(negedge CLK) begin
        logic        e_rdy, e_resp;
        logic [31:0] e_data;
        logic [33:0] sr;
        int          t;
        logic        new_err;
        e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'h0;
        if (m_owner == 4) begin
            e_rdy  = (m_err_cyc == 2);
            e_resp = 1'b1;
        end else if (m_owner >= 0) begin
            sr = slave_resp(m_owner);
            e_rdy = sr[33]; e_resp = sr[32]; e_data = sr[31:0];
        end
        t = model_target(bus.M_HADDR, bus.M_HSIZE);
        chk("hready", {31'h0, bus.M_HREADY}, {31'h0, e_rdy});
        chk("hresp",  {31'h0, bus.M_HRESP},  {31'h0, e_resp});
        if (!(m_owner == 4 && m_err_cyc == 2))
            chk("hrdata", bus.M_HRDATA, e_data);
        chk("hsel", {28'h0, bus.S3_HSEL, bus.S2_HSEL, bus.S1_HSEL, bus.S0_HSEL},
            {28'h0, t == 3, t == 2, t == 1, t == 0});
        chk("bcast", {bus.S_HADDR[31:3], bus.S_HREADY, bus.S_HTRANS},
            {bus.M_HADDR[31:3], e_rdy, bus.M_HTRANS});
        chk("err_count", {24'h0, ERR_COUNT}, m_cnt);
        chk("err_addr", ERR_ADDR, m_addr);

        // advance to the state after the coming rising edge
        if (RES) begin
            m_owner = -1; m_err_cyc = 0; m_cnt = 0; m_addr = 32'h0;
        end else begin
            new_err = 1'b0;
            if (m_owner == 4 && m_err_cyc == 1) begin
                m_err_cyc = 2;
            end else if (e_rdy) begin
                m_err_cyc = 0;
                if (!bus.M_HTRANS[1])   m_owner = -1;
                else if (t < 0) begin
                    m_owner = 4; m_err_cyc = 1; new_err = 1'b1;
                end else                m_owner = t;
            end
            if (new_err) begin
                m_addr = bus.M_HADDR;
                m_cnt  = ERR_CLR ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            end else if (ERR_CLR) begin
                m_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a);
        bus.M_HTRANS = tr;
        bus.M_HWRITE = wr;
        bus.M_HSIZE  = sz;
        bus.M_HADDR  = a;
    endtask

    task automatic pin_out(input string name, input logic rdy, input logic resp);
        chk({name, "_rdy"},  {31'h0, bus.M_HREADY}, {31'h0, rdy});
        chk({name, "_resp"}, {31'h0, bus.M_HRESP},  {31'h0, resp});
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r = {16'h0000, r[15:0]};
            1: r = {16'h8000, r[15:0]};
            2: r = {20'h40000, r[11:0]};
            3: r = {20'h40001, r[11:0]};
            4: r = 32'h2000_0000 | {16'h0, r[15:0]};
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        RES = 1'b1;
        ERR_CLR = 1'b0;
        drv(IDLE, 1'b0, 3'd2, 32'h0);
        bus.M_HWDATA = 32'h0;
        bus.S1_HREADYOUT = 1'b1; bus.S1_HRESP = 1'b0; bus.S1_HRDATA = 32'h1111_1111;
        bus.S2_HREADYOUT = 1'b1; bus.S2_HRESP = 1'b0; bus.S2_HRDATA = 32'h2222_2222;
        bus.S3_HREADYOUT = 1'b1; bus.S3_HRESP = 1'b0; bus.S3_HRDATA = 32'h3333_3333;
        repeat (2) @(posedge CLK);
        #1 RES = 1'b0;
        @(negedge CLK);
        pin_out("reset", 1'b1, 1'b0);
        chk("reset_rdata", bus.M_HRDATA, 32'h0);
        chk("reset_cnt", {24'h0, ERR_COUNT}, 32'd0);
        chk("reset_addr", ERR_ADDR, 32'h0);

        // RAM word write then read
        step(); drv(NONSEQ, 1'b1, 3'd2, 32'h0000_0010);
        @(negedge CLK); chk("wr_s0_hsel", {31'h0, bus.S0_HSEL}, 32'd1);
        step(); bus.M_HWDATA = 32'hDEAD_BEEF; drv(NONSEQ, 1'b0, 3'd2, 32'h0000_0010);
        @(negedge CLK); chk("rd_s0_hsel", {31'h0, bus.S0_HSEL}, 32'd1); pin_out("wr_dp", 1'b1, 1'b0);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h0000_0010);
        @(negedge CLK); chk("ram_rdata", bus.M_HRDATA, 32'hDEAD_BEEF); pin_out("rd_dp", 1'b1, 1'b0);

        // slave 3 read with three wait states
        step(); drv(NONSEQ, 1'b0, 3'd2, 32'h4000_1004);
        @(negedge CLK); chk("s3_hsel", {31'h0, bus.S3_HSEL}, 32'd1); chk("s2_hsel", {31'h0, bus.S2_HSEL}, 32'd0);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h4000_1004);
        bus.S3_HREADYOUT = 1'b0; bus.S3_HRDATA = 32'hCAFE_0003;
        @(negedge CLK); chk("s3_wait1", {31'h0, bus.M_HREADY}, 32'd0);
        step(); @(negedge CLK); chk("s3_wait2", {31'h0, bus.M_HREADY}, 32'd0);
        step(); @(negedge CLK); chk("s3_wait3", {31'h0, bus.M_HREADY}, 32'd0);
        chk("s2_hsel_w", {31'h0, bus.S2_HSEL}, 32'd0);
        step(); bus.S3_HREADYOUT = 1'b1;
        @(negedge CLK); pin_out("s3_done", 1'b1, 1'b0); chk("s3_rdata", bus.M_HRDATA, 32'hCAFE_0003);

        // unmapped NONSEQ read
        step(); drv(NONSEQ, 1'b0, 3'd2, 32'h2000_0000);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h2000_0000);
        @(negedge CLK); pin_out("unm_err1", 1'b0, 1'b1);
        chk("unm_cnt", {24'h0, ERR_COUNT}, 32'd1); chk("unm_addr", ERR_ADDR, 32'h2000_0000);
        step(); @(negedge CLK); pin_out("unm_err2", 1'b1, 1'b1);
        step(); @(negedge CLK); pin_out("unm_ok", 1'b1, 1'b0);

        // misaligned word read, then IDLE to unmapped space
        step(); drv(NONSEQ, 1'b0, 3'd2, 32'h0000_0002);
        @(negedge CLK); chk("mis_s0_hsel", {31'h0, bus.S0_HSEL}, 32'd0);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h2000_0000);
        @(negedge CLK); pin_out("mis_err1", 1'b0, 1'b1);
        step(); @(negedge CLK); pin_out("mis_err2", 1'b1, 1'b1);
        step(); @(negedge CLK); pin_out("idle_ok", 1'b1, 1'b0);
        chk("idle_cnt", {24'h0, ERR_COUNT}, 32'd2);

        // clear alone, then back-to-back errors
        step(); ERR_CLR = 1'b1;
        step(); ERR_CLR = 1'b0; drv(NONSEQ, 1'b0, 3'd2, 32'h2000_0000);
        @(negedge CLK); chk("clr_cnt", {24'h0, ERR_COUNT}, 32'd0); chk("clr_addr", ERR_ADDR, 32'h0000_0002);
        step(); @(negedge CLK); pin_out("b2b_err1a", 1'b0, 1'b1);
        step(); @(negedge CLK); pin_out("b2b_err2a", 1'b1, 1'b1);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h2000_0000);
        @(negedge CLK); pin_out("b2b_err1b", 1'b0, 1'b1);
        step(); @(negedge CLK); pin_out("b2b_err2b", 1'b1, 1'b1);
        step(); @(negedge CLK); pin_out("b2b_ok", 1'b1, 1'b0);
        chk("b2b_cnt", {24'h0, ERR_COUNT}, 32'd2);

        // 300 more errors saturate the counter
        step(); drv(NONSEQ, 1'b0, 3'd2, 32'h2000_0000);
        repeat (600) step();
        drv(IDLE, 1'b0, 3'd2, 32'h2000_0000);
        repeat (3) step();
        @(negedge CLK); chk("sat_cnt", {24'h0, ERR_COUNT}, 32'h0000_00FF);

        // clear coincident with a new error
        step(); drv(NONSEQ, 1'b0, 3'd2, 32'h2000_0040); ERR_CLR = 1'b1;
        step(); drv(IDLE, 1'b0, 3'd2, 32'h2000_0040); ERR_CLR = 1'b0;
        @(negedge CLK); chk("clr_err_cnt", {24'h0, ERR_COUNT}, 32'd1); chk("clr_err_addr", ERR_ADDR, 32'h2000_0040);
        repeat (2) step();

        // reset during ERR1, then a RAM read
        step(); drv(NONSEQ, 1'b0, 3'd2, 32'h2000_0000);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h2000_0000); RES = 1'b1;
        @(negedge CLK); pin_out("rst_err1", 1'b0, 1'b1);
        step(); RES = 1'b0; drv(NONSEQ, 1'b0, 3'd2, 32'h0000_0010);
        @(negedge CLK); pin_out("rst_out", 1'b1, 1'b0); chk("rst_cnt", {24'h0, ERR_COUNT}, 32'd0);
        step(); drv(IDLE, 1'b0, 3'd2, 32'h0000_0010);
        @(negedge CLK); pin_out("rst_rd", 1'b1, 1'b0); chk("rst_rdata", bus.M_HRDATA, 32'hDEAD_BEEF);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            RES     = ($urandom_range(0, 199) == 0);
            ERR_CLR = ($urandom_range(0, 49) == 0);
            drv($urandom_range(0, 3) == 0 ? IDLE : {1'b1, 1'($urandom_range(0, 1))},
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : 3'd2,
                rand_addr());
            bus.M_HWDATA     = $urandom;
            bus.S1_HREADYOUT = ($urandom_range(0, 3) != 0);
            bus.S2_HREADYOUT = ($urandom_range(0, 3) != 0);
            bus.S3_HREADYOUT = ($urandom_range(0, 3) != 0);
            bus.S1_HRESP     = ($urandom_range(0, 7) == 0);
            bus.S2_HRESP     = ($urandom_range(0, 7) == 0);
            bus.S3_HRESP     = ($urandom_range(0, 7) == 0);
            bus.S1_HRDATA    = $urandom;
            bus.S2_HRDATA    = $urandom;
            bus.S3_HRDATA    = $urandom;
        end
        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
